instruction_fetch: RTL and testbench

- Fetch stage between program_counter and decode/register_file.
- Reads the 32-bit word at the current PC over a simple request/ready memory handshake and latches it into an instruction register.
- Pulses the PC increment and presents the instruction and its sliced fields to decode with a valid/taken handshake.
- Supports flush on jump.

---
 rtl/instruction_fetch_pkg.sv | 28 ++
 rtl/instruction_fetch.sv | 163 ++++++++++++++++
 tb/tb_instruction_fetch.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the fetch stage: FSM state encodings, instruction
// field bit positions and the immediate-type encoding.
package instruction_fetch_pkg;

  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_WAIT  = 2'd1,
    FS_HOLD  = 2'd2,
    FS_FAULT = 2'd3
  } fetch_state_e;

  localparam int OPCODE_HI   = 31;
  localparam int OPCODE_LO   = 26;
  localparam int IMM_TYPE_HI = 25;
  localparam int IMM_TYPE_LO = 24;
  localparam int RD_HI       = 23;
  localparam int RD_LO       = 20;
  localparam int RS_HI       = 19;
  localparam int RS_LO       = 16;
  localparam int IMM_HI      = 15;
  localparam int IMM_LO      = 0;

  localparam logic [1:0] IT_BOTTOM   = 2'b00;
  localparam logic [1:0] IT_TOP      = 2'b01;
  localparam logic [1:0] IT_UNSIGNED = 2'b10;
  localparam logic [1:0] IT_SIGNED   = 2'b11;

endpackage

// File: rtl/instruction_fetch.sv
// Fetch stage: reads the word at the PC, holds it for decode, pulses pc_inc.
// Define FETCH_TIMEOUT_EN to add a sticky fault when memory never answers.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// FS_IDLE  | no request outstanding, instruction register empty
// FS_WAIT  | mem_read asserted, waiting for mem_ready (maybe discarding)
// FS_HOLD  | instruction valid, waiting for decode to take it
// FS_FAULT | memory timed out; left only by reset
module instruction_fetch #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  input  logic        flush,
  input  logic [31:0] pc_value,
  output logic        pc_inc,
  output logic [31:0] mem_address,
  output logic        mem_read,
  input  logic        mem_ready,
  input  logic [31:0] mem_data_in,
  output logic        instr_valid,
  input  logic        instr_taken,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [1:0]  imm_type,
  output logic [3:0]  rd_index,
  output logic [3:0]  rs_index,
  output logic [15:0] immediate,
  output logic        fetch_fault
);
  import instruction_fetch_pkg::*;

  fetch_state_e state_q, state_d;
  logic [31:0]  addr_q, addr_d;
  logic [31:0]  instr_q, instr_d;
  logic         read_q, read_d;
  logic         valid_q, valid_d;
  logic         pc_inc_q, pc_inc_d;
  logic         discard_q, discard_d;

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fault_q, fault_d;
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    instr_d   = instr_q;
    read_d    = read_q;
    valid_d   = valid_q;
    pc_inc_d  = 1'b0;
    discard_d = discard_q;
`ifdef FETCH_TIMEOUT_EN
    cnt_d     = '0;
    fault_d   = fault_q;
`endif
    case (state_q)
      FS_IDLE: begin
        if (run && !flush) begin
          addr_d  = pc_value;
          read_d  = 1'b1;
          state_d = FS_WAIT;
        end
      end
      FS_WAIT: begin
        if (mem_ready) begin
          read_d    = 1'b0;
          discard_d = 1'b0;
          if (discard_q || flush) begin
            state_d = FS_IDLE;
          end else begin
            instr_d  = mem_data_in;
            valid_d  = 1'b1;
            pc_inc_d = 1'b1;
            state_d  = FS_HOLD;
          end
        end else begin
          // A flushed request stays on the bus until memory answers, then is dropped.
          if (flush) discard_d = 1'b1;
`ifdef FETCH_TIMEOUT_EN
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            read_d    = 1'b0;
            fault_d   = 1'b1;
            discard_d = 1'b0;
            state_d   = FS_FAULT;
          end
`endif
        end
      end
      FS_HOLD: begin
        if (flush) begin
          valid_d = 1'b0;
          state_d = FS_IDLE;
        end else if (instr_taken) begin
          valid_d = 1'b0;
          if (run) begin
            addr_d  = pc_value;
            read_d  = 1'b1;
            state_d = FS_WAIT;
          end else begin
            state_d = FS_IDLE;
          end
        end
      end
      FS_FAULT: ;
      default: state_d = FS_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= FS_IDLE;
      addr_q    <= '0;
      instr_q   <= '0;
      read_q    <= 1'b0;
      valid_q   <= 1'b0;
      pc_inc_q  <= 1'b0;
      discard_q <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      cnt_q     <= '0;
      fault_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      instr_q   <= instr_d;
      read_q    <= read_d;
      valid_q   <= valid_d;
      pc_inc_q  <= pc_inc_d;
      discard_q <= discard_d;
`ifdef FETCH_TIMEOUT_EN
      cnt_q     <= cnt_d;
      fault_q   <= fault_d;
`endif
    end
  end

`ifdef FETCH_TIMEOUT_EN
  assign fetch_fault = fault_q;
`else
  assign fetch_fault = 1'b0;
  // The timeout length has no effect when the counter is not built.
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  assign pc_inc      = pc_inc_q;
  assign mem_address = addr_q;
  assign mem_read    = read_q;
  assign instr_valid = valid_q;
  assign instr       = instr_q;
  assign opcode      = instr_q[OPCODE_HI:OPCODE_LO];
  assign imm_type    = instr_q[IMM_TYPE_HI:IMM_TYPE_LO];
  assign rd_index    = instr_q[RD_HI:RD_LO];
  assign rs_index    = instr_q[RS_HI:RS_LO];
  assign immediate   = instr_q[IMM_HI:IMM_LO];

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus a
// randomized run against a cycle-level behavioural model of the fetch rules.
module tb_instruction_fetch;
  import instruction_fetch_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        run = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] pc_value = '0;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_data_in = '0;
  logic        instr_taken = 1'b0;
  logic        pc_inc, mem_read, instr_valid, fetch_fault;
  logic [31:0] mem_address, instr;
  logic [5:0]  opcode;
  logic [1:0]  imm_type;
  logic [3:0]  rd_index, rs_index;
  logic [15:0] immediate;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_instr;

  instruction_fetch #(.TIMEOUT_CYCLES(16)) dut (
    .clock(clock), .reset(reset), .run(run), .flush(flush), .pc_value(pc_value),
    .pc_inc(pc_inc), .mem_address(mem_address), .mem_read(mem_read),
    .mem_ready(mem_ready), .mem_data_in(mem_data_in), .instr_valid(instr_valid),
    .instr_taken(instr_taken), .instr(instr), .opcode(opcode), .imm_type(imm_type),
    .rd_index(rd_index), .rs_index(rs_index), .immediate(immediate),
    .fetch_fault(fetch_fault)
  );

  always #5 clock = ~clock;

  // Advance one edge; the program counter steps by 4 on the edge after pc_inc.
  task automatic tick();
    logic inc_seen;
    inc_seen = pc_inc;
    @(posedge clock);
    #1;
    if (inc_seen) pc_value = pc_value + 32'd4;
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic test_reset();
    reset = 1'b0; run = 1'b1; mem_ready = 1'b1; mem_data_in = 32'hffff_ffff;
    tick(); tick();
    checks++;
    if ({mem_read, instr_valid, pc_inc, fetch_fault} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got %b exp 0000", {mem_read, instr_valid, pc_inc, fetch_fault});
    end
    checks++;
    if ({mem_address, instr} !== 64'd0) begin
      errors++; $display("FAIL reset_regs got addr=%h instr=%h exp 0", mem_address, instr);
    end
    checks++;
    if ({opcode, imm_type, rd_index, rs_index, immediate} !== 32'd0) begin
      errors++; $display("FAIL reset_fields got %h exp 0", {opcode, imm_type, rd_index, rs_index, immediate});
    end
    run = 1'b0; mem_ready = 1'b0; mem_data_in = '0;
  endtask

  task automatic test_start();
    pc_value = 32'd0; run = 1'b1; reset = 1'b1;
    tick();
    checks++;
    if ({mem_read, instr_valid, mem_address} !== {1'b1, 1'b0, 32'd0}) begin
      errors++; $display("FAIL start_req got read=%b valid=%b addr=%h exp 1 0 0", mem_read, instr_valid, mem_address);
    end
    mem_ready = 1'b1; mem_data_in = 32'h1423_beef; run = 1'b0;
    tick();
    checks++;
    if ({mem_read, instr_valid, pc_inc} !== 3'b011 || instr !== 32'h1423_beef) begin
      errors++; $display("FAIL start_capture got rvi=%b instr=%h exp 011 1423beef", {mem_read, instr_valid, pc_inc}, instr);
    end
    checks++;
    if (opcode !== 6'h05 || imm_type !== IT_BOTTOM || rd_index !== 4'h2 || rs_index !== 4'h3 || immediate !== 16'hbeef) begin
      errors++; $display("FAIL start_fields got %h %b %h %h %h exp 05 00 2 3 beef", opcode, imm_type, rd_index, rs_index, immediate);
    end
    mem_ready = 1'b0;
    tick();
    checks++;
    if ({instr_valid, pc_inc} !== 2'b10 || opcode !== 6'h05 || immediate !== 16'hbeef) begin
      errors++; $display("FAIL start_single_inc got valid=%b inc=%b op=%h imm=%h exp 1 0 05 beef", instr_valid, pc_inc, opcode, immediate);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w;
    run = 1'b1; instr_taken = 1'b1;
    tick();
    checks++;
    if ({mem_read, instr_valid, mem_address} !== {1'b1, 1'b0, 32'd4}) begin
      errors++; $display("FAIL b2b_next got read=%b valid=%b addr=%h exp 1 0 4", mem_read, instr_valid, mem_address);
    end
    instr_taken = 1'b0; w = $urandom; mem_ready = 1'b1; mem_data_in = w; run = 1'b0;
    tick();
    checks++;
    if ({instr_valid, pc_inc} !== 2'b11 || instr !== w) begin
      errors++; $display("FAIL b2b_capture got vi=%b instr=%h exp 11 %h", {instr_valid, pc_inc}, instr, w);
    end
    mem_ready = 1'b0;
    tick();
    instr_taken = 1'b1;
    tick();
    checks++;
    if ({mem_read, instr_valid} !== 2'b00) begin
      errors++; $display("FAIL b2b_idle got rv=%b exp 00", {mem_read, instr_valid});
    end
    instr_taken = 1'b0;
  endtask

  task automatic test_wait_states();
    logic [31:0] w;
    pc_value = 32'h100; run = 1'b1;
    tick();
    run = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({mem_read, pc_inc, instr_valid, mem_address} !== {3'b100, 32'h100}) begin
        errors++; $display("FAIL wait_stable[%0d] got riv=%b addr=%h exp 100 00000100", i, {mem_read, pc_inc, instr_valid}, mem_address);
      end
      tick();
    end
    w = $urandom; mem_ready = 1'b1; mem_data_in = w;
    tick();
    checks++;
    if ({mem_read, instr_valid, pc_inc} !== 3'b011 || instr !== w) begin
      errors++; $display("FAIL wait_capture got rvi=%b instr=%h exp 011 %h", {mem_read, instr_valid, pc_inc}, instr, w);
    end
    mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({instr_valid, pc_inc} !== 2'b10) begin
        errors++; $display("FAIL wait_one_inc[%0d] got vi=%b exp 10", i, {instr_valid, pc_inc});
      end
    end
    instr_taken = 1'b1;
    tick();
    instr_taken = 1'b0;
    last_instr = w;
  endtask

  task automatic test_flush_wait();
    logic [31:0] w;
    pc_value = 32'h200; run = 1'b1;
    tick();
    flush = 1'b1; pc_value = 32'h300; run = 1'b0;
    tick();
    flush = 1'b0;
    checks++;
    if ({mem_read, mem_address} !== {1'b1, 32'h200}) begin
      errors++; $display("FAIL flushw_keep got read=%b addr=%h exp 1 00000200", mem_read, mem_address);
    end
    tick();
    mem_ready = 1'b1; mem_data_in = 32'hdead_beef;
    tick();
    mem_ready = 1'b0;
    checks++;
    if ({mem_read, instr_valid, pc_inc} !== 3'b000 || instr !== last_instr) begin
      errors++; $display("FAIL flushw_drop got rvi=%b instr=%h exp 000 %h", {mem_read, instr_valid, pc_inc}, instr, last_instr);
    end
    run = 1'b1;
    tick();
    checks++;
    if ({mem_read, mem_address} !== {1'b1, 32'h300}) begin
      errors++; $display("FAIL flushw_idle_refetch got read=%b addr=%h exp 1 00000300", mem_read, mem_address);
    end
    w = $urandom; mem_ready = 1'b1; mem_data_in = w; run = 1'b0;
    tick();
    mem_ready = 1'b0;
    checks++;
    if ({instr_valid, pc_inc} !== 2'b11 || instr !== w) begin
      errors++; $display("FAIL flushw_next_capture got vi=%b instr=%h exp 11 %h", {instr_valid, pc_inc}, instr, w);
    end
    last_instr = w;
    tick();
  endtask

  task automatic test_flush_hold();
    flush = 1'b1; instr_taken = 1'b1; run = 1'b1;
    tick();
    flush = 1'b0; instr_taken = 1'b0; run = 1'b0;
    checks++;
    if ({mem_read, instr_valid, pc_inc} !== 3'b000) begin
      errors++; $display("FAIL flushh_clear got rvi=%b exp 000", {mem_read, instr_valid, pc_inc});
    end
    run = 1'b1;
    tick();
    run = 1'b0; flush = 1'b1; mem_ready = 1'b1; mem_data_in = $urandom;
    tick();
    flush = 1'b0; mem_ready = 1'b0;
    checks++;
    if ({mem_read, instr_valid, pc_inc} !== 3'b000 || instr !== last_instr) begin
      errors++; $display("FAIL flush_with_ready got rvi=%b instr=%h exp 000 %h", {mem_read, instr_valid, pc_inc}, instr, last_instr);
    end
  endtask

  task automatic test_timeout();
    pc_value = 32'h400; run = 1'b1;
    tick();
    run = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    for (int i = 1; i <= 15; i++) begin
      tick();
      checks++;
      if ({mem_read, fetch_fault} !== 2'b10) begin
        errors++; $display("FAIL timeout_early[%0d] got rf=%b exp 10", i, {mem_read, fetch_fault});
      end
    end
    tick();
    checks++;
    if ({mem_read, fetch_fault} !== 2'b01) begin
      errors++; $display("FAIL timeout_fault got rf=%b exp 01", {mem_read, fetch_fault});
    end
    for (int i = 0; i < 6; i++) begin
      flush = i[0]; run = i[1]; mem_ready = i[2];
      tick();
      checks++;
      if ({mem_read, instr_valid, pc_inc, fetch_fault} !== 4'b0001) begin
        errors++; $display("FAIL timeout_sticky[%0d] got rvif=%b exp 0001", i, {mem_read, instr_valid, pc_inc, fetch_fault});
      end
    end
    flush = 1'b0; run = 1'b0; mem_ready = 1'b0; reset = 1'b0;
    tick();
    reset = 1'b1;
    checks++;
    if ({mem_read, fetch_fault} !== 2'b00) begin
      errors++; $display("FAIL timeout_reset got rf=%b exp 00", {mem_read, fetch_fault});
    end
`else
    for (int i = 0; i < 40; i++) begin
      tick();
      checks++;
      if ({mem_read, fetch_fault, mem_address} !== {2'b10, 32'h400}) begin
        errors++; $display("FAIL no_timeout[%0d] got rf=%b addr=%h exp 10 00000400", i, {mem_read, fetch_fault}, mem_address);
      end
    end
    flush = 1'b1; mem_ready = 1'b1; mem_data_in = $urandom;
    tick();
    flush = 1'b0; mem_ready = 1'b0;
    checks++;
    if ({mem_read, instr_valid, pc_inc} !== 3'b000) begin
      errors++; $display("FAIL no_timeout_exit got rvi=%b exp 000", {mem_read, instr_valid, pc_inc});
    end
`endif
  endtask

  task automatic test_reset_mid_wait();
    pc_value = 32'h40; run = 1'b1;
    tick();
    run = 1'b0;
    checks++;
    if (mem_read !== 1'b1) begin
      errors++; $display("FAIL rstwait_pre got read=%b exp 1", mem_read);
    end
    reset = 1'b0;
    tick();
    checks++;
    if ({mem_read, instr_valid, pc_inc, fetch_fault, mem_address, instr} !== 68'd0) begin
      errors++; $display("FAIL rstwait_clear got rvif=%b addr=%h instr=%h exp 0", {mem_read, instr_valid, pc_inc, fetch_fault}, mem_address, instr);
    end
    reset = 1'b1; mem_ready = 1'b1; mem_data_in = $urandom;
    tick();
    mem_ready = 1'b0;
    checks++;
    if ({mem_read, instr_valid, pc_inc, instr} !== 35'd0) begin
      errors++; $display("FAIL rstwait_late_ready got rvi=%b instr=%h exp 000 0", {mem_read, instr_valid, pc_inc}, instr);
    end
  endtask

  // Random traffic against a rule-level model: each cycle's outputs follow from
  // the previous cycle's outputs and inputs; fetched words come from mem_word().
  task automatic test_random();
    logic p_read, p_valid, drop, lat_active;
    logic [31:0] p_instr, p_pc, m_addr, exp_addr, exp_instr;
    logic i_run, i_flush, i_ready, i_taken;
    logic [2:0] exp_rvi;
    logic chk_addr, chk_instr;
    int lat;
    reset = 1'b0; run = 1'b0; flush = 1'b0; mem_ready = 1'b0; instr_taken = 1'b0;
    tick();
    reset = 1'b1; pc_value = 32'h1000;
    drop = 1'b0; lat_active = 1'b0; lat = 0; m_addr = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      i_run   = ($urandom_range(7) != 0);
      i_flush = !pc_inc && ($urandom_range(9) == 0);
      i_taken = !pc_inc && ($urandom_range(1) == 1);
      i_ready = 1'b0;
      mem_data_in = $urandom;
      if (mem_read) begin
        if (!lat_active) begin
          lat_active = 1'b1; lat = $urandom_range(3);
        end
        if (lat == 0) begin
          i_ready = 1'b1; mem_data_in = mem_word(mem_address); lat_active = 1'b0;
        end else begin
          lat--;
        end
      end else if ($urandom_range(7) == 0) begin
        i_ready = 1'b1;
      end
      if (i_flush) pc_value = $urandom & 32'hffff_fffc;
      p_read = mem_read; p_valid = instr_valid; p_instr = instr; p_pc = pc_value;
      run = i_run; flush = i_flush; mem_ready = i_ready; instr_taken = i_taken;
      tick();
      chk_addr = 1'b0; chk_instr = 1'b0; exp_addr = '0; exp_instr = '0;
      if (p_read) begin
        if (i_ready) begin
          if (i_flush || drop) exp_rvi = 3'b000;
          else begin
            exp_rvi = 3'b011; chk_instr = 1'b1; exp_instr = mem_word(m_addr);
          end
          drop = 1'b0;
        end else begin
          exp_rvi = 3'b100; chk_addr = 1'b1; exp_addr = m_addr;
          if (i_flush) drop = 1'b1;
        end
      end else if (p_valid) begin
        if (i_flush) exp_rvi = 3'b000;
        else if (i_taken) begin
          exp_rvi = {i_run, 2'b00};
          if (i_run) begin
            chk_addr = 1'b1; exp_addr = p_pc; m_addr = p_pc;
          end
        end else begin
          exp_rvi = 3'b010; chk_instr = 1'b1; exp_instr = p_instr;
        end
      end else begin
        if (i_run && !i_flush) begin
          exp_rvi = 3'b100; chk_addr = 1'b1; exp_addr = p_pc; m_addr = p_pc;
        end else exp_rvi = 3'b000;
      end
      checks++;
      if ({mem_read, instr_valid, pc_inc} !== exp_rvi || (chk_addr && mem_address !== exp_addr) ||
          (chk_instr && instr !== exp_instr) || fetch_fault !== 1'b0) begin
        errors++;
        $display("FAIL random[%0d] got rvi=%b addr=%h instr=%h fault=%b exp rvi=%b addr=%h instr=%h fault=0",
                 cyc, {mem_read, instr_valid, pc_inc}, mem_address, instr, fetch_fault, exp_rvi, exp_addr, exp_instr);
      end
    end
    run = 1'b0; flush = 1'b0; mem_ready = 1'b0; instr_taken = 1'b0;
  endtask

  initial begin
    last_instr = '0;
    #1;
    test_reset();
    test_start();
    test_back_to_back();
    test_wait_states();
    test_flush_wait();
    test_flush_hold();
    test_timeout();
    test_reset_mid_wait();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
